fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 56 +++++
 tb/tb_fetch_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: ARM pipeline instruction fetch with the PC register and the IF/ID register.
// Ports:
//   CLK, RESET (synchronous, active-low)
//   InstrF                  instruction-memory read data for PCF
//   BranchTakenE/ALUResultE execute-stage branch redirect
//   PCSrcW/ResultW          writeback R15 redirect
//   StallF, StallD, FlushD  hazard-unit control
//   PCF, PCPlus4F           fetch address and its successor
//   InstrD, PCPlus8D, ValidD IF/ID register outputs to decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] InstrF,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);
    logic [31:0] pcNext;
    logic        redirect;

    assign redirect = BranchTakenE | PCSrcW;
    assign pcNext   = BranchTakenE ? ALUResultE : PCSrcW ? ResultW : PCPlus4F;
    assign PCPlus4F = PCF + 32'd4;

    // A redirect beats StallF; every PC load is word-aligned.
    always_ff @(posedge CLK) begin
        if (!RESET)
            PCF <= {RESET_PC[31:2], 2'b00};
        else if (redirect || !StallF)
            PCF <= {pcNext[31:2], 2'b00};
    end

    always_ff @(posedge CLK) begin
        if (!RESET || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCPlus8D <= PCF + 32'd8;
            ValidD   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage.
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] InstrF;
    logic        BranchTakenE = 1'b0;
    logic [31:0] ALUResultE = 32'd0;
    logic        PCSrcW = 1'b0;
    logic [31:0] ResultW = 32'd0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [31:0] PCF, PCPlus4F, InstrD, PCPlus8D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .CLK(CLK), .RESET(RESET), .InstrF(InstrF),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD),
        .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    always #5 CLK = ~CLK;

    // Memory model: word at address k is E000_0000 + k.
    assign InstrF = 32'hE000_0000 + PCF;

    typedef struct {
        logic        rst, bt, ps, sf, sd, fd;
        logic [31:0] alu, res;
        logic [31:0] ePc, eInstr, eP8;
        logic        eV;
    } vec_t;

    typedef struct {
        logic [31:0] pc, instr, p8;
        logic        v;
        string       tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic rst, logic bt, logic [31:0] alu, logic ps, logic [31:0] res,
                                logic sf, logic sd, logic fd,
                                logic [31:0] ePc, logic [31:0] eInstr, logic [31:0] eP8, logic eV);
        vec_t r;
        r.rst = rst; r.bt = bt; r.alu = alu; r.ps = ps; r.res = res;
        r.sf = sf; r.sd = sd; r.fd = fd;
        r.ePc = ePc; r.eInstr = eInstr; r.eP8 = eP8; r.eV = eV;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        exp_t e;
        exp_t g;
        @(negedge CLK);
        RESET = v.rst; BranchTakenE = v.bt; ALUResultE = v.alu;
        PCSrcW = v.ps; ResultW = v.res;
        StallF = v.sf; StallD = v.sd; FlushD = v.fd;
        e.pc = v.ePc; e.instr = v.eInstr; e.p8 = v.eP8; e.v = v.eV; e.tag = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        g = sb.pop_front();
        check({g.tag, " PCF"}, PCF, g.pc);
        check({g.tag, " PCPlus4F"}, PCPlus4F, g.pc + 32'd4);
        check({g.tag, " InstrD"}, InstrD, g.instr);
        check({g.tag, " PCPlus8D"}, PCPlus8D, g.p8);
        check({g.tag, " ValidD"}, {31'd0, ValidD}, {31'd0, g.v});
    endtask

    initial begin
        //               rst bt alu        ps res          sf sd fd  PCF          InstrD       PCPlus8D     V
        vecs.push_back(mk(0, 0, 0,         0, 0,           0, 0, 0, 32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0, 0,         0, 0,           0, 0, 0, 32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0, 0,         0, 0,           0, 0, 0, 32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h4,        32'hE000_0000, 32'h8,       1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h8,        32'hE000_0004, 32'hC,       1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'hC,        32'hE000_0008, 32'h10,      1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h10,       32'hE000_000C, 32'h14,      1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           1, 1, 0, 32'h10,       32'hE000_000C, 32'h14,      1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           1, 1, 0, 32'h10,       32'hE000_000C, 32'h14,      1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h14,       32'hE000_0010, 32'h18,      1));
        vecs.push_back(mk(1, 1, 32'h100,   0, 0,           0, 0, 1, 32'h100,      32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h104,      32'hE000_0100, 32'h108,     1));
        vecs.push_back(mk(1, 1, 32'h200,   1, 32'h300,     1, 0, 1, 32'h200,      32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         1, 32'h303,     1, 0, 1, 32'h300,      32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h304,      32'hE000_0300, 32'h308,     1));
        vecs.push_back(mk(1, 0, 0,         1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,     32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h0,        32'hDFFF_FFFC, 32'h4,       1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 1, 1, 32'h4,        32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h8,        32'hE000_0004, 32'hC,       1));
        vecs.push_back(mk(1, 0, 0,         1, 32'h3C,      0, 0, 1, 32'h3C,       32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h40,       32'hE000_003C, 32'h44,      1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           1, 1, 0, 32'h40,       32'hE000_003C, 32'h44,      1));
        vecs.push_back(mk(0, 1, 32'h500,   1, 32'h600,     1, 1, 1, 32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0,         0, 0,           0, 0, 0, 32'h4,        32'hE000_0000, 32'h8,       1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           1, 0, 0, 32'h4,        32'hE000_0004, 32'hC,       1));
        vecs.push_back(mk(1, 0, 0,         0, 0,           1, 0, 0, 32'h4,        32'hE000_0004, 32'hC,       1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Misaligned branch target near the top of memory, then wrap to zero.
        apply(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0), "hs_align");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hDFFF_FFFC, 32'h4, 1), "hs_wrap");
        // Stall held over several cycles, released, then reset with stall active.
        apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'hDFFF_FFFC, 32'h4, 1), "hs_st1");
        apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'hDFFF_FFFC, 32'h4, 1), "hs_st2");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'hE000_0000, 32'h8, 1), "hs_rel");
        apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 0), "hs_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
